instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/mips_pkg.sv | 26 ++
 rtl/instr_encoder_if.sv | 21 ++
 rtl/instr_pack.sv | 24 ++
 rtl/instr_encoder.sv | 135 +++++++++++++
 tb/tb_instr_encoder.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcodes, request-op codes and FSM state type for the instruction encoder
package mips_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] FUNCT_ADD = 6'b100000;

    localparam logic [1:0] REQ_ADD = 2'b00;
    localparam logic [1:0] REQ_LW  = 2'b01;
    localparam logic [1:0] REQ_BEQ = 2'b10;
    localparam logic [1:0] REQ_ILL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENC,
        ST_WR,
        ST_CHK,
        ST_DONE
    } state_t;

    function automatic logic op_legal(input logic [1:0] op);
        return op != REQ_ILL;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - encode-request channel between a requester and the instruction encoder
interface instr_encoder_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [4:0]  req_rs;
    logic [4:0]  req_rt;
    logic [4:0]  req_rd;
    logic [15:0] req_imm;
    logic        req_last;

    modport master (
        output req_valid, req_op, req_rs, req_rt, req_rd, req_imm, req_last,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_op, req_rs, req_rt, req_rd, req_imm, req_last,
        output req_ready
    );
endinterface

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - combinational mapping of request fields to a 32-bit MIPS instruction word
module instr_pack
    import mips_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    output logic [31:0] word
);

    // Illegal op packs to zero; the encoder never writes it anyway.
    always_comb begin
        word = 32'h0;
        case (op)
            REQ_ADD: word = {OP_RTYPE, rs, rt, rd, 5'b00000, FUNCT_ADD};
            REQ_LW:  word = {OP_LW, rs, rt, imm};
            REQ_BEQ: word = {OP_BEQ, rs, rt, imm};
            default: word = 32'h0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - request-driven instruction encoder writing words to instruction memory; optional read-back via INSTR_ENC_READBACK_EN
module instr_encoder
    import mips_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    instr_encoder_if.slave    req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic [31:0]       imem_rdata,
    output logic              done,
    output logic [15:0]       instr_count,
    output logic              err_illegal,
    output logic              err_mismatch
);

    state_t      state;
    logic [1:0]  cap_op;
    logic [4:0]  cap_rs;
    logic [4:0]  cap_rt;
    logic [4:0]  cap_rd;
    logic [15:0] cap_imm;
    logic        cap_last;
    logic [31:0] packed_word;

    instr_pack u_pack (
        .op   (cap_op),
        .rs   (cap_rs),
        .rt   (cap_rt),
        .rd   (cap_rd),
        .imm  (cap_imm),
        .word (packed_word)
    );

`ifndef INSTR_ENC_READBACK_EN
    logic unused_rdata;
    assign unused_rdata = ^imem_rdata;
`endif

    // Control FSM with all outputs registered; req_ready mirrors "next state is IDLE".
    // With read-back, the address advance is deferred to the end of CHK so the
    // memory still presents the word just written while it is being compared.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            req.req_ready <= 1'b1;
            imem_we       <= 1'b0;
            imem_addr     <= ADDR_W'(BASE_ADDR);
            imem_wdata    <= 32'h0;
            done          <= 1'b0;
            instr_count   <= 16'h0;
            err_illegal   <= 1'b0;
            err_mismatch  <= 1'b0;
            cap_op        <= 2'b00;
            cap_rs        <= 5'd0;
            cap_rt        <= 5'd0;
            cap_rd        <= 5'd0;
            cap_imm       <= 16'h0;
            cap_last      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            done    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req.req_valid) begin
                        cap_op        <= req.req_op;
                        cap_rs        <= req.req_rs;
                        cap_rt        <= req.req_rt;
                        cap_rd        <= req.req_rd;
                        cap_imm       <= req.req_imm;
                        cap_last      <= req.req_last;
                        state         <= ST_ENC;
                        req.req_ready <= 1'b0;
                    end
                end
                ST_ENC: begin
                    if (op_legal(cap_op)) begin
                        imem_wdata <= packed_word;
                        imem_we    <= 1'b1;
                        state      <= ST_WR;
                    end else begin
                        err_illegal   <= 1'b1;
                        state         <= ST_IDLE;
                        req.req_ready <= 1'b1;
                    end
                end
                ST_WR: begin
                    if (instr_count != 16'hFFFF) begin
                        instr_count <= instr_count + 16'd1;
                    end
`ifdef INSTR_ENC_READBACK_EN
                    state <= ST_CHK;
`else
                    imem_addr <= imem_addr + ADDR_W'(4);
                    if (cap_last) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        state         <= ST_IDLE;
                        req.req_ready <= 1'b1;
                    end
`endif
                end
`ifdef INSTR_ENC_READBACK_EN
                ST_CHK: begin
                    if (imem_rdata != imem_wdata) begin
                        err_mismatch <= 1'b1;
                    end
                    imem_addr <= imem_addr + ADDR_W'(4);
                    if (cap_last) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        state         <= ST_IDLE;
                        req.req_ready <= 1'b1;
                    end
                end
`endif
                ST_DONE: begin
                    state         <= ST_IDLE;
                    req.req_ready <= 1'b1;
                end
                default: begin
                    state         <= ST_IDLE;
                    req.req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder (default and INSTR_ENC_READBACK_EN builds)
module tb_instr_encoder;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    instr_encoder_if rq ();
    instr_encoder_if rq4 ();

    logic        imem_we, imem_we4;
    logic [9:0]  imem_addr;
    logic [3:0]  imem_addr4;
    logic [31:0] imem_wdata, imem_wdata4, imem_rdata, imem_rdata4;
    logic        done, done4;
    logic [15:0] instr_count, instr_count4;
    logic        err_illegal, err_illegal4, err_mismatch, err_mismatch4;

    instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .req(rq.slave),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .imem_rdata(imem_rdata), .done(done), .instr_count(instr_count),
        .err_illegal(err_illegal), .err_mismatch(err_mismatch)
    );

    instr_encoder #(.ADDR_W(4), .BASE_ADDR(0)) dut4 (
        .clk(clk), .reset(reset), .req(rq4.slave),
        .imem_we(imem_we4), .imem_addr(imem_addr4), .imem_wdata(imem_wdata4),
        .imem_rdata(imem_rdata4), .done(done4), .instr_count(instr_count4),
        .err_illegal(err_illegal4), .err_mismatch(err_mismatch4)
    );

    // Instruction memories: write on strobe, combinational read, optional bit-0 corruption.
    logic [31:0] mem  [256];
    logic [31:0] mem4 [4];
    logic        corrupt_en = 1'b0;
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        for (int i = 0; i < 4; i++) mem4[i] = 32'h0;
    end
    always @(posedge clk) begin
        if (imem_we)  mem[imem_addr[9:2]]   <= imem_wdata;
        if (imem_we4) mem4[imem_addr4[3:2]] <= imem_wdata4;
    end
    assign imem_rdata  = mem[imem_addr[9:2]] ^ {31'd0, corrupt_en};
    assign imem_rdata4 = mem4[imem_addr4[3:2]];

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int addr_m, addr4_m, count_m;
    logic ill_m, mm_m;

    function automatic logic [31:0] encode(input logic [1:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd,
                                           input logic [15:0] imm);
        logic [31:0] w;
        case (op)
            2'b00:   w = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'h20;
            2'b01:   w = (32'h23 << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
            2'b10:   w = (32'h04 << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        addr_m = 0; addr4_m = 0; count_m = 0; ill_m = 1'b0; mm_m = 1'b0;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd,
                         input logic [15:0] imm, input logic last);
        rq.req_valid = v;  rq4.req_valid = v;
        rq.req_op = op;    rq4.req_op = op;
        rq.req_rs = rs;    rq4.req_rs = rs;
        rq.req_rt = rt;    rq4.req_rt = rt;
        rq.req_rd = rd;    rq4.req_rd = rd;
        rq.req_imm = imm;  rq4.req_imm = imm;
        rq.req_last = last; rq4.req_last = last;
    endtask

    task automatic check_reset_state();
        chk("rst_we", 32'(imem_we), 0);
        chk("rst_addr", 32'(imem_addr), 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_count", 32'(instr_count), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ill", 32'(err_illegal), 0);
        chk("rst_mm", 32'(err_mismatch), 0);
        chk("rst_ready", 32'(rq.req_ready), 1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        drive(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state();
        reset = 1'b0;
        model_reset();
    endtask

    // One request end to end; returns the word and 4-bit-instance address seen at the write strobe.
    task automatic run_req(input logic [1:0] op, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [15:0] imm, input logic last,
                           input logic corrupt, output logic [31:0] word_seen,
                           output logic [3:0] addr4_seen);
        logic [31:0] exp;
        word_seen = 32'h0;
        addr4_seen = 4'h0;
        @(negedge clk);
        chk("idle_ready", 32'(rq.req_ready), 1);
        drive(1'b1, op, rs, rt, rd, imm, last);
        corrupt_en = corrupt;
        @(negedge clk);
        // Junk on the inputs while busy must be ignored.
        drive(1'($urandom_range(0, 1)), 2'($urandom), 5'($urandom), 5'($urandom),
              5'($urandom), 16'($urandom), 1'($urandom));
        chk("enc_ready", 32'(rq.req_ready), 0);
        chk("enc_we", 32'(imem_we), 0);
        if (op == 2'b11) begin
            @(negedge clk);
            drive(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0);
            ill_m = 1'b1;
            chk("ill_we", 32'(imem_we), 0);
            chk("ill_flag", 32'(err_illegal), 32'(ill_m));
            chk("ill_ready", 32'(rq.req_ready), 1);
            chk("ill_addr", 32'(imem_addr), 32'(addr_m));
            chk("ill_count", 32'(instr_count), 32'(count_m));
            corrupt_en = 1'b0;
            return;
        end
        @(negedge clk);
        drive(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0);
        exp = encode(op, rs, rt, rd, imm);
        chk("wr_we", 32'(imem_we), 1);
        chk("wr_addr", 32'(imem_addr), 32'(addr_m));
        chk("wr_wdata", imem_wdata, exp);
        chk("wr_we4", 32'(imem_we4), 1);
        chk("wr_addr4", 32'(imem_addr4), 32'(addr4_m));
        word_seen = imem_wdata;
        addr4_seen = imem_addr4;
`ifdef INSTR_ENC_READBACK_EN
        @(negedge clk);
        chk("chk_we", 32'(imem_we), 0);
        chk("chk_ready", 32'(rq.req_ready), 0);
        if (corrupt) mm_m = 1'b1;
`endif
        addr_m = (addr_m + 4) % 1024;
        addr4_m = (addr4_m + 4) % 16;
        if (count_m < 16'hFFFF) count_m++;
        @(negedge clk);
        corrupt_en = 1'b0;
        chk("post_we", 32'(imem_we), 0);
        chk("post_addr", 32'(imem_addr), 32'(addr_m));
        chk("post_addr4", 32'(imem_addr4), 32'(addr4_m));
        chk("post_count", 32'(instr_count), 32'(count_m));
        chk("post_done", 32'(done), 32'(last));
        chk("post_ready", 32'(rq.req_ready), 32'(!last));
        chk("post_mm", 32'(err_mismatch), 32'(mm_m));
        chk("post_ill", 32'(err_illegal), 32'(ill_m));
        if (last) begin
            @(negedge clk);
            chk("done_clr", 32'(done), 0);
            chk("done_ready", 32'(rq.req_ready), 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic [3:0]  a4;
        logic [1:0]  op;
        drive(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0);
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state();
        reset = 1'b0;

        // add r3 = r1 + r2
        run_req(2'b00, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0, 1'b0, w, a4);
        chk("add_word", w, 32'h00221820);
        chk("add_count", 32'(instr_count), 1);

        // lw then beq(last) from a fresh reset
        apply_reset();
        run_req(2'b01, 5'd4, 5'd5, 5'd0, 16'h0010, 1'b0, 1'b0, w, a4);
        chk("lw_word", w, 32'h8C850010);
        run_req(2'b10, 5'd1, 5'd2, 5'd0, 16'hFFFE, 1'b1, 1'b0, w, a4);
        chk("beq_word", w, 32'h1022FFFE);
        chk("beq_count", 32'(instr_count), 2);

        // illegal op: no write, sticky flag, address unchanged
        run_req(2'b11, 5'd7, 5'd8, 5'd9, 16'h1234, 1'b0, 1'b0, w, a4);
        run_req(2'b00, 5'd9, 5'd8, 5'd7, 16'h0, 1'b0, 1'b0, w, a4);
        chk("ill_sticky", 32'(err_illegal), 1);

        // reset while in ENC abandons the write
        @(negedge clk);
        drive(1'b1, 2'b01, 5'd3, 5'd3, 5'd3, 16'hBEEF, 1'b0);
        @(negedge clk);
        drive(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_state();
        model_reset();
        @(negedge clk);
        chk("rst_enc_we", 32'(imem_we), 0);
        chk("rst_enc_ready", 32'(rq.req_ready), 1);

        // 4-bit address space wraps on the fifth write
        for (int i = 0; i < 5; i++) begin
            run_req(2'b00, 5'(i), 5'(i + 1), 5'(i + 2), 16'h0, 1'b0, 1'b0, w, a4);
        end
        chk("wrap4_fifth", 32'(a4), 0);

        // randomized mix
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            run_req(op, 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom),
                    1'($urandom_range(0, 4) == 0), 1'b0, w, a4);
        end

`ifdef INSTR_ENC_READBACK_EN
        apply_reset();
        run_req(2'b01, 5'd2, 5'd3, 5'd0, 16'h0040, 1'b0, 1'b0, w, a4);
        chk("rb_clean", 32'(err_mismatch), 0);
        run_req(2'b00, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0, 1'b1, w, a4);
        chk("rb_mismatch", 32'(err_mismatch), 1);
        run_req(2'b10, 5'd4, 5'd4, 5'd0, 16'h0008, 1'b1, 1'b0, w, a4);
        chk("rb_sticky", 32'(err_mismatch), 1);
`else
        chk("mm_tied", 32'(err_mismatch), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
